uart_tx: RTL and testbench

UART serial transmitter. It is the transmit-side counterpart of the 16x-oversampling receive path. It accepts parallel bytes over a valid/ready handshake and serialises each one as a start bit, DATA_BITS data bits (LSB first), an optional parity bit and 1 or 2 stop bits. It contains its own 1x baud counter, restarted at each frame, so bit periods are exact from the start edge.

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// A private 1x baud counter restarts at every handshake, so each bit is held for exactly BAUD_DIV clocks.
module uart_tx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    generate
        if (PARITY < 0 || PARITY > 2) begin : g_badParity
            $error("uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_badStop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (BAUD_DIV < 2) begin : g_badDiv
            $error("uart_tx: CLOCK_FREQ / BAUD_RATE must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_badData
            $error("uart_tx: DATA_BITS must be in 5..9");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q,     state_d;
    logic [CNT_W-1:0]     baudCnt_q,   baudCnt_d;
    logic [IDX_W-1:0]     bitIdx_q,    bitIdx_d;
    logic [DATA_BITS-1:0] shiftReg_q,  shiftReg_d;
    logic                 parityBit_q, parityBit_d;
    logic                 txLine_q,    txLine_d;
    logic                 txReady_q,   txReady_d;
    logic                 txBusy_q,    txBusy_d;
    logic                 baudDone;

    assign baudDone = (baudCnt_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            baudCnt_q   <= '0;
            bitIdx_q    <= '0;
            shiftReg_q  <= '0;
            parityBit_q <= 1'b0;
            txLine_q    <= 1'b1;
            txReady_q   <= 1'b1;
            txBusy_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            baudCnt_q   <= baudCnt_d;
            bitIdx_q    <= bitIdx_d;
            shiftReg_q  <= shiftReg_d;
            parityBit_q <= parityBit_d;
            txLine_q    <= txLine_d;
            txReady_q   <= txReady_d;
            txBusy_q    <= txBusy_d;
        end
    end

    // Outputs are computed one cycle ahead so tx/tx_ready/tx_busy come straight from flops.
    always_comb begin
        state_d     = state_q;
        baudCnt_d   = baudDone ? '0 : baudCnt_q + 1'b1;
        bitIdx_d    = bitIdx_q;
        shiftReg_d  = shiftReg_q;
        parityBit_d = parityBit_q;
        txLine_d    = txLine_q;
        txReady_d   = txReady_q;
        txBusy_d    = txBusy_q;

        case (state_q)
            S_IDLE: begin
                baudCnt_d = '0;
                if (tx_valid && txReady_q) begin
                    shiftReg_d  = tx_data;
                    parityBit_d = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    bitIdx_d    = '0;
                    state_d     = S_START;
                    txLine_d    = 1'b0;
                    txReady_d   = 1'b0;
                    txBusy_d    = 1'b1;
                end
            end
            S_START: begin
                if (baudDone) begin
                    state_d  = S_DATA;
                    txLine_d = shiftReg_q[0];
                end
            end
            S_DATA: begin
                if (baudDone) begin
                    if (bitIdx_q == LAST_DATA) begin
                        bitIdx_d = '0;
                        if (PARITY != 0) begin
                            state_d  = S_PARITY;
                            txLine_d = parityBit_q;
                        end else begin
                            state_d  = S_STOP;
                            txLine_d = 1'b1;
                        end
                    end else begin
                        bitIdx_d   = bitIdx_q + 1'b1;
                        shiftReg_d = shiftReg_q >> 1;
                        txLine_d   = shiftReg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baudDone) begin
                    state_d  = S_STOP;
                    txLine_d = 1'b1;
                end
            end
            S_STOP: begin
                if (baudDone) begin
                    if (bitIdx_q == LAST_STOP) begin
                        bitIdx_d  = '0;
                        state_d   = S_IDLE;
                        txLine_d  = 1'b1;
                        txReady_d = 1'b1;
                        txBusy_d  = 1'b0;
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                baudCnt_d = '0;
                bitIdx_d  = '0;
                txLine_d  = 1'b1;
                txReady_d = 1'b1;
                txBusy_d  = 1'b0;
            end
        endcase
    end

    assign tx       = txLine_q;
    assign tx_ready = txReady_q;
    assign tx_busy  = txBusy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three fast instances (8N1, 8E2, 8O1) share stimulus, a fourth runs default parameters.
// A per-instance queue holds the expected line level for every cycle of the frames the model has accepted.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] txData;
    logic [7:0] txData3;
    logic       txValid;
    logic       txValid3;
    logic [3:0] txO;
    logic [3:0] readyO;
    logic [3:0] busyO;

    int compared   = 0;
    int mismatched = 0;
    int cur        = 0;

    bit expQ [4][$];
    int cfgParity [4] = '{0, 2, 1, 0};
    int cfgStops  [4] = '{1, 2, 1, 1};
    int cfgDiv    [4] = '{10, 10, 10, 5208};

    uart_tx #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .tx_data(txData), .tx_valid(txValid),
        .tx_ready(readyO[0]), .tx(txO[0]), .tx_busy(busyO[0]));

    uart_tx #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .tx_data(txData), .tx_valid(txValid),
        .tx_ready(readyO[1]), .tx(txO[1]), .tx_busy(busyO[1]));

    uart_tx #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .tx_data(txData), .tx_valid(txValid),
        .tx_ready(readyO[2]), .tx(txO[2]), .tx_busy(busyO[2]));

    uart_tx dut3 (
        .clk(clk), .rst(rst), .tx_data(txData3), .tx_valid(txValid3),
        .tx_ready(readyO[3]), .tx(txO[3]), .tx_busy(busyO[3]));

    always #5 clk = ~clk;

    // Expands one accepted byte into the full per-clock line waveform for instance i.
    function automatic void pushFrame(int i, logic [7:0] d);
        bit p;
        for (int k = 0; k < cfgDiv[i]; k++) expQ[i].push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < cfgDiv[i]; k++) expQ[i].push_back(d[b]);
        if (cfgParity[i] != 0) begin
            p = (cfgParity[i] == 2) ? ^d : ~^d;
            for (int k = 0; k < cfgDiv[i]; k++) expQ[i].push_back(p);
        end
        for (int k = 0; k < cfgStops[i] * cfgDiv[i]; k++) expQ[i].push_back(1'b1);
    endfunction

    // Model: an idle instance accepts a valid byte; a busy one consumes one expected cycle per clock.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) expQ[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (expQ[i].size() == 0) begin
                    if ((i < 3) ? txValid : txValid3)
                        pushFrame(i, (i < 3) ? txData : txData3);
                end else begin
                    void'(expQ[i].pop_front());
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, each instance's {tx, tx_ready, tx_busy} must match the model.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            logic [2:0] e;
            e = (expQ[i].size() != 0) ? {expQ[i][0], 2'b01} : 3'b110;
            checkOutput($sformatf("line%0d", i), {txO[i], readyO[i], busyO[i]}, e);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goTo(input int n);
        repeat (n - cur) @(negedge clk);
        cur = n;
    endtask

    // One-cycle valid pulse on the shared port; returns on the negedge after the handshake edge.
    task automatic applyStimulus(input logic [7:0] d);
        @(negedge clk);
        txData  = d;
        txValid = 1'b1;
        @(negedge clk);
        txValid = 1'b0;
        cur     = 0;
    endtask

    logic a5Bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        rst      = 1'b1;
        txData   = 8'h00;
        txData3  = 8'h00;
        txValid  = 1'b0;
        txValid3 = 1'b0;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(50);
        checkOutput("idle_after_reset", {txO[0], readyO[0], busyO[0]}, 3'b110);

        applyStimulus(8'hA5);
        checkOutput("handshake_latency", {txO[0], readyO[0], busyO[0]}, 3'b001);
        for (int k = 0; k < 10; k++) begin
            goTo(5 + 10 * k);
            checkOutput($sformatf("a5_bit%0d", k), {2'b00, txO[0]}, {2'b00, a5Bits[k]});
        end
        goTo(99);
        checkOutput("a5_ready_99", {2'b00, readyO[0]}, 3'b000);
        goTo(100);
        checkOutput("a5_ready_100", {2'b00, readyO[0]}, 3'b001);
        waitCycles(30);

        applyStimulus(8'h07);
        goTo(95);
        checkOutput("even_parity_bit", {2'b00, txO[1]}, 3'b001);
        checkOutput("odd_parity_bit", {2'b00, txO[2]}, 3'b000);
        goTo(109);
        checkOutput("odd_ready_109", {2'b00, readyO[2]}, 3'b000);
        goTo(110);
        checkOutput("odd_ready_110", {2'b00, readyO[2]}, 3'b001);
        checkOutput("even_stop2_110", {txO[1], readyO[1], busyO[1]}, 3'b101);
        goTo(119);
        checkOutput("even_ready_119", {2'b00, readyO[1]}, 3'b000);
        goTo(120);
        checkOutput("even_ready_120", {2'b00, readyO[1]}, 3'b001);
        waitCycles(10);

        @(negedge clk);
        txData  = 8'h55;
        txValid = 1'b1;
        @(negedge clk);
        cur    = 0;
        txData = 8'h0F;
        goTo(100);
        checkOutput("b2b_gap_idle", {txO[0], readyO[0], busyO[0]}, 3'b110);
        goTo(101);
        checkOutput("b2b_second_start", {txO[0], readyO[0], busyO[0]}, 3'b001);
        txValid = 1'b0;
        goTo(116);
        checkOutput("b2b_0f_bit0", {2'b00, txO[0]}, 3'b001);
        goTo(156);
        checkOutput("b2b_0f_bit4", {2'b00, txO[0]}, 3'b000);
        waitCycles(130);

        applyStimulus(8'h3C);
        goTo(20);
        txData = 8'hFF;
        goTo(22);
        txValid = 1'b1;
        goTo(23);
        txValid = 1'b0;
        txData  = 8'h81;
        goTo(140);
        checkOutput("no_extra_frame", {txO[0], readyO[0], busyO[0]}, 3'b110);

        applyStimulus(8'h00);
        goTo(35);
        checkOutput("pre_reset_bit", {2'b00, txO[0]}, 3'b000);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset", {txO[0], readyO[0], busyO[0]}, 3'b110);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h96);
        goTo(25);
        checkOutput("post_reset_bit1", {2'b00, txO[0]}, 3'b001);
        waitCycles(130);

        for (int it = 0; it < 25; it++) begin
            waitCycles($urandom_range(0, 15));
            txData  = 8'($urandom);
            txValid = 1'b1;
            waitCycles($urandom_range(1, 3));
            txValid = 1'b0;
            repeat ($urandom_range(20, 140)) begin
                @(negedge clk);
                txData  = 8'($urandom);
                txValid = ($urandom_range(0, 9) == 0);
            end
            txValid = 1'b0;
        end
        waitCycles(130);

        @(negedge clk);
        txData3  = 8'h00;
        txValid3 = 1'b1;
        @(negedge clk);
        txValid3 = 1'b0;
        cur      = 0;
        goTo(5207);
        checkOutput("def_start_end", {txO[3], readyO[3], busyO[3]}, 3'b001);
        goTo(46871);
        checkOutput("def_last_data", {2'b00, txO[3]}, 3'b000);
        goTo(46872);
        checkOutput("def_stop_begin", {2'b00, txO[3]}, 3'b001);
        goTo(52079);
        checkOutput("def_frame_end", {txO[3], readyO[3], busyO[3]}, 3'b101);
        goTo(52080);
        checkOutput("def_frame_done", {txO[3], readyO[3], busyO[3]}, 3'b110);
        waitCycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
